// File: rtl/imem_responder.sv
// imem_responder: memory side of the instruction-fetch interface.
// One outstanding fetch at a time. WAIT_STATES extra cycles pass between
// accept and response, and the word is then held until rsp_ready. A flush
// discards whatever is in flight. A load port fills the word array.
//
// Optional build macro IMEM_BOUNDS_CHECK_EN: adds rsp_err and returns a NOP
// (32'h0) for out-of-range or misaligned fetches instead of wrapping.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no request outstanding, req_ready=1
// S_WAIT | request accepted, counting down wait states
// S_RESP | rsp_valid=1, word held until rsp_ready

module imem_responder #(
  parameter int DEPTH       = 64,
  parameter int AW          = 6,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [31:0]   req_addr,
  output logic          req_ready,
  output logic          rsp_valid,
  output logic [31:0]   rsp_data,
  output logic [31:0]   rsp_addr,
`ifdef IMEM_BOUNDS_CHECK_EN
  output logic          rsp_err,
`endif
  input  logic          rsp_ready,
  input  logic          flush,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Wait-state counter is 4 bits wide, so WAIT_STATES is meaningful up to 15.
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic          accept;
  logic          rd_en;
  logic [AW-1:0] rd_idx;
  logic [31:0]   mem [DEPTH];

  // Only the word-index bits of the address select memory in the wrapping build.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef IMEM_BOUNDS_CHECK_EN
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  logic req_err;
  logic pend_err;
  logic rd_err;

  // A fetch outside the array or not word aligned is answered with a NOP.
  assign req_err = (req_addr >= ADDR_LIMIT) || (req_addr[1:0] != 2'b00);
`endif

  assign rsp_valid = (state == S_RESP);

  // Next-state, handshake and read-strobe decode; flush overrides everything.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    accept    = 1'b0;
    rd_en     = 1'b0;
    rd_idx    = rsp_addr[AW+1:2];
`ifdef IMEM_BOUNDS_CHECK_EN
    rd_err    = pend_err;
`endif

    if (flush) begin
      state_nxt = S_IDLE;
      cnt_nxt   = 4'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          req_ready = 1'b1;
        end
        S_WAIT: begin
          cnt_nxt = cnt - 4'd1;
          // cnt==0 cannot occur here; treated as done so the FSM cannot stall.
          if (cnt <= 4'd1) begin
            rd_en     = 1'b1;
            cnt_nxt   = 4'd0;
            state_nxt = S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            req_ready = 1'b1;
            if (!req_valid) begin
              state_nxt = S_IDLE;
            end
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end

    // Nothing is accepted while reset is still asserted.
    if (reset) begin
      req_ready = 1'b0;
    end

    accept = req_ready && req_valid;

    // An accept from IDLE or a back-to-back accept from RESP starts a new fetch.
    if (accept) begin
      cnt_nxt = WS;
      if (WS == 4'd0) begin
        // No wait states: read on the accept edge using the live address.
        rd_en     = 1'b1;
        rd_idx    = req_addr[AW+1:2];
`ifdef IMEM_BOUNDS_CHECK_EN
        rd_err    = req_err;
`endif
        state_nxt = S_RESP;
      end else begin
        state_nxt = S_WAIT;
      end
    end
  end

  // State register and wait-state counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Response address is captured at accept and held through the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_addr <= 32'd0;
    end else if (accept) begin
      rsp_addr <= req_addr;
    end
  end

`ifdef IMEM_BOUNDS_CHECK_EN
  // Error flag for the outstanding request, needed when the read is deferred.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_err <= 1'b0;
    end else if (accept) begin
      pend_err <= req_err;
    end
  end

  // Response word and error flag, registered together; bad fetches skip the array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data <= 32'd0;
      rsp_err  <= 1'b0;
    end else if (rd_en) begin
      rsp_data <= rd_err ? 32'h0000_0000 : mem[rd_idx];
      rsp_err  <= rd_err;
    end
  end
`else
  // Response word register; the array read happens only on the read strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data <= 32'd0;
    end else if (rd_en) begin
      rsp_data <= mem[rd_idx];
    end
  end
`endif

  // Program-load write; no reset so contents survive reset. A same-edge read
  // of the written word sees the old value.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam logic [31:0] W0 = 32'h2008_0005;
  localparam logic [31:0] W1 = 32'h2009_0003;
  localparam logic [31:0] W2 = 32'h200A_0007;
  localparam logic [31:0] W3 = 32'h200B_0009;
  localparam logic [31:0] WNEW = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        load_we;
  logic [5:0]  load_addr;
  logic [31:0] load_data;

  // dut1: WAIT_STATES=1
  logic        rv1, rq1, vv1, rr1;
  logic [31:0] ra1, d1, a1;
  // dut0: WAIT_STATES=0
  logic        rv0, rq0, vv0, rr0;
  logic [31:0] ra0, d0, a0;
`ifdef IMEM_BOUNDS_CHECK_EN
  logic        e1, e0;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] words [4];

  imem_responder #(.DEPTH(64), .AW(6), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(rv1), .req_addr(ra1), .req_ready(rq1),
    .rsp_valid(vv1), .rsp_data(d1), .rsp_addr(a1),
`ifdef IMEM_BOUNDS_CHECK_EN
    .rsp_err(e1),
`endif
    .rsp_ready(rr1), .flush(flush),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
  );

  imem_responder #(.DEPTH(64), .AW(6), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(rv0), .req_addr(ra0), .req_ready(rq0),
    .rsp_valid(vv0), .rsp_data(d0), .rsp_addr(a0),
`ifdef IMEM_BOUNDS_CHECK_EN
    .rsp_err(e0),
`endif
    .rsp_ready(rr0), .flush(flush),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++; if (vv1 !== 1'b0) begin bad++; $display("FAIL reset_valid1 got=%b want=0", vv1); end
    total++; if (d1 !== 32'd0) begin bad++; $display("FAIL reset_data1 got=%h want=00000000", d1); end
    total++; if (a1 !== 32'd0) begin bad++; $display("FAIL reset_addr1 got=%h want=00000000", a1); end
    total++; if (vv0 !== 1'b0) begin bad++; $display("FAIL reset_valid0 got=%b want=0", vv0); end
    reset = 1'b0;
    #1;
    total++; if (rq1 !== 1'b1) begin bad++; $display("FAIL reset_ready1 got=%b want=1", rq1); end
    total++; if (rq0 !== 1'b1) begin bad++; $display("FAIL reset_ready0 got=%b want=1", rq0); end
    step();
  endtask

  task automatic load_program();
    for (int i = 0; i < 4; i++) begin
      load_we   = 1'b1;
      load_addr = 6'(i);
      load_data = words[i];
      step();
    end
    load_we = 1'b0;
  endtask

  task automatic test_basic();
    rr1 = 1'b1; rv1 = 1'b1; ra1 = 32'h0;
    #1;
    total++; if (rq1 !== 1'b1) begin bad++; $display("FAIL basic_idle_ready got=%b want=1", rq1); end
    step();
    rv1 = 1'b0;
    total++; if (vv1 !== 1'b0) begin bad++; $display("FAIL basic_wait_valid got=%b want=0", vv1); end
    total++; if (rq1 !== 1'b0) begin bad++; $display("FAIL basic_wait_ready got=%b want=0", rq1); end
    step();
    total++; if (vv1 !== 1'b1) begin bad++; $display("FAIL basic_rsp0_valid got=%b want=1", vv1); end
    total++; if (d1 !== W0) begin bad++; $display("FAIL basic_rsp0_data got=%h want=%h", d1, W0); end
    total++; if (a1 !== 32'h0) begin bad++; $display("FAIL basic_rsp0_addr got=%h want=00000000", a1); end
`ifdef IMEM_BOUNDS_CHECK_EN
    total++; if (e1 !== 1'b0) begin bad++; $display("FAIL basic_rsp0_err got=%b want=0", e1); end
`endif
    rv1 = 1'b1; ra1 = 32'h4;
    #1;
    total++; if (rq1 !== 1'b1) begin bad++; $display("FAIL basic_b2b_ready got=%b want=1", rq1); end
    step();
    rv1 = 1'b0;
    total++; if (vv1 !== 1'b0) begin bad++; $display("FAIL basic_wait1_valid got=%b want=0", vv1); end
    step();
    total++; if (vv1 !== 1'b1) begin bad++; $display("FAIL basic_rsp1_valid got=%b want=1", vv1); end
    total++; if (d1 !== W1) begin bad++; $display("FAIL basic_rsp1_data got=%h want=%h", d1, W1); end
    total++; if (a1 !== 32'h4) begin bad++; $display("FAIL basic_rsp1_addr got=%h want=00000004", a1); end
    step();
    total++; if (vv1 !== 1'b0) begin bad++; $display("FAIL basic_consumed got=%b want=0", vv1); end
  endtask

  task automatic test_stream();
    rr0 = 1'b1; rv0 = 1'b1; ra0 = 32'h0;
    step();
    for (int i = 0; i < 3; i++) begin
      total++; if (vv0 !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b want=1", i, vv0); end
      total++; if (d0 !== words[i]) begin bad++; $display("FAIL stream_data[%0d] got=%h want=%h", i, d0, words[i]); end
      total++; if (a0 !== 32'(i * 4)) begin bad++; $display("FAIL stream_addr[%0d] got=%h want=%h", i, a0, 32'(i * 4)); end
      if (i < 2) ra0 = 32'((i + 1) * 4);
      else rv0 = 1'b0;
      #1;
      total++; if (rq0 !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b want=1", i, rq0); end
      step();
    end
    total++; if (vv0 !== 1'b0) begin bad++; $display("FAIL stream_end_valid got=%b want=0", vv0); end
  endtask

  task automatic test_backpressure();
    rr1 = 1'b0; rv1 = 1'b1; ra1 = 32'h4;
    step();
    rv1 = 1'b0;
    step();
    rv1 = 1'b1; ra1 = 32'h8;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (vv1 !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", i, vv1); end
      total++; if (d1 !== W1) begin bad++; $display("FAIL bp_data[%0d] got=%h want=%h", i, d1, W1); end
      total++; if (a1 !== 32'h4) begin bad++; $display("FAIL bp_addr[%0d] got=%h want=00000004", i, a1); end
      total++; if (rq1 !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=0", i, rq1); end
      step();
    end
    rv1 = 1'b0; rr1 = 1'b1;
    step();
    total++; if (vv1 !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", vv1); end
  endtask

  task automatic test_flush();
    rr1 = 1'b1; rv1 = 1'b1; ra1 = 32'h8;
    step();
    rv1 = 1'b0; flush = 1'b1;
    #1;
    total++; if (rq1 !== 1'b0) begin bad++; $display("FAIL flush_wait_ready got=%b want=0", rq1); end
    step();
    flush = 1'b0;
    total++; if (vv1 !== 1'b0) begin bad++; $display("FAIL flush_valid_after got=%b want=0", vv1); end
    rv1 = 1'b1; ra1 = 32'hC;
    #1;
    total++; if (rq1 !== 1'b1) begin bad++; $display("FAIL flush_idle_ready got=%b want=1", rq1); end
    step();
    rv1 = 1'b0;
    total++; if (vv1 !== 1'b0) begin bad++; $display("FAIL flush_no_stale got=%b want=0", vv1); end
    step();
    total++; if (vv1 !== 1'b1) begin bad++; $display("FAIL flush_next_valid got=%b want=1", vv1); end
    total++; if (d1 !== W3) begin bad++; $display("FAIL flush_next_data got=%h want=%h", d1, W3); end
    total++; if (a1 !== 32'hC) begin bad++; $display("FAIL flush_next_addr got=%h want=0000000c", a1); end
    step();
    // flush in IDLE blocks the accept of a simultaneous request
    flush = 1'b1; rv1 = 1'b1; ra1 = 32'h0;
    #1;
    total++; if (rq1 !== 1'b0) begin bad++; $display("FAIL flush_cycle_ready got=%b want=0", rq1); end
    step();
    flush = 1'b0;
    #1;
    total++; if (rq1 !== 1'b1) begin bad++; $display("FAIL flush_not_accepted got=%b want=1", rq1); end
    rv1 = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    rr1 = 1'b0; rv1 = 1'b1; ra1 = 32'h0;
    step();
    rv1 = 1'b0;
    step();
    total++; if (vv1 !== 1'b1) begin bad++; $display("FAIL areset_pre_valid got=%b want=1", vv1); end
    #2 reset = 1'b1;
    #1;
    total++; if (vv1 !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b want=0", vv1); end
    total++; if (d1 !== 32'd0) begin bad++; $display("FAIL areset_data got=%h want=00000000", d1); end
    #1 reset = 1'b0;
    step();
    rr1 = 1'b1; rv1 = 1'b1; ra1 = 32'h4;
    step();
    rv1 = 1'b0;
    step();
    total++; if (vv1 !== 1'b1) begin bad++; $display("FAIL areset_refetch_valid got=%b want=1", vv1); end
    total++; if (d1 !== W1) begin bad++; $display("FAIL areset_refetch_data got=%h want=%h", d1, W1); end
    step();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a;
    logic [31:0] exp_b;
`ifdef IMEM_BOUNDS_CHECK_EN
    exp_a = 32'h0; exp_b = 32'h0;
`else
    exp_a = W0; exp_b = W1;
`endif
    rr1 = 1'b1; rv1 = 1'b1; ra1 = 32'h100;
    step();
    rv1 = 1'b0;
    step();
    total++; if (vv1 !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b want=1", vv1); end
    total++; if (d1 !== exp_a) begin bad++; $display("FAIL wrap_data got=%h want=%h", d1, exp_a); end
    total++; if (a1 !== 32'h100) begin bad++; $display("FAIL wrap_addr got=%h want=00000100", a1); end
`ifdef IMEM_BOUNDS_CHECK_EN
    total++; if (e1 !== 1'b1) begin bad++; $display("FAIL wrap_err got=%b want=1", e1); end
`endif
    step();
    rv1 = 1'b1; ra1 = 32'h106;
    step();
    rv1 = 1'b0;
    step();
    total++; if (d1 !== exp_b) begin bad++; $display("FAIL misalign_data got=%h want=%h", d1, exp_b); end
`ifdef IMEM_BOUNDS_CHECK_EN
    total++; if (e1 !== 1'b1) begin bad++; $display("FAIL misalign_err got=%b want=1", e1); end
`endif
    step();
  endtask

  task automatic test_read_before_write();
    rr0 = 1'b1; rv0 = 1'b1; ra0 = 32'h8;
    load_we = 1'b1; load_addr = 6'd2; load_data = WNEW;
    step();
    rv0 = 1'b0; load_we = 1'b0;
    total++; if (d0 !== W2) begin bad++; $display("FAIL rbw_old_data got=%h want=%h", d0, W2); end
    step();
    rv0 = 1'b1; ra0 = 32'h8;
    step();
    rv0 = 1'b0;
    total++; if (d0 !== WNEW) begin bad++; $display("FAIL rbw_new_data got=%h want=%h", d0, WNEW); end
    step();
  endtask

  initial begin
    words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;
    reset = 1'b1; flush = 1'b0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
    rv1 = 1'b0; ra1 = '0; rr1 = 1'b0;
    rv0 = 1'b0; ra0 = '0; rr0 = 1'b0;
    test_reset();
    load_program();
    test_basic();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_wrap();
    test_read_before_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
